// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial operand feeder: state encoding and frame sizing helpers.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    SHIFT = 2'b10
  } state_t;

  function automatic int frame_len(input int width, input int pad);
    return width + pad;
  endfunction

  // Counter must be able to hold FRAME itself, hence FRAME+1.
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Bit-position counter for one serial frame: synchronous load-to-zero, count enable,
// and a terminal-count flag on the last bit position.
module frame_bit_counter #(
  parameter int FRAME = 10,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(FRAME - 1));

endmodule

// File: rtl/serial_operand_feeder.sv
// Serialises a parallel operand LSB-first with PAD trailing zeros, preceded by a
// one-cycle clear pulse, for the bit-serial multiply-by-3 FSM.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PAD   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_hold,
  output logic             ser_clear,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             frame_last,
  output logic             busy
);

  localparam int FRAME = frame_len(WIDTH, PAD);
  localparam int CW    = cnt_width(FRAME);

  state_t           state, next_state;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             advance;

  frame_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (advance),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Handshake and stream qualifiers depend only on registered state and ser_hold.
  assign ser_valid  = (state == SHIFT) && !ser_hold;
  assign frame_last = ser_valid && tc;
  assign in_ready   = (state == IDLE) || frame_last;
  assign ser_clear  = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign ser_bit    = shreg[0];
  assign accept     = in_valid && in_ready;
  assign advance    = ser_valid && !tc;

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CLEAR;
      CLEAR:   next_state = SHIFT;
      SHIFT:   if (frame_last) next_state = accept ? CLEAR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        shreg <= '0;
    else if (accept)  shreg <= FRAME'(in_data);
    else if (advance) shreg <= shreg >> 1;
  end

endmodule
